// File: rtl/dcmac_0_axis_pkt_gen_ctx_sched_if.sv
// Request/grant bus between the packet-generator buffer-context stage and its
// channel scheduler.
//   i_dat_req / i_dat_req_id  : context stage raises a data request for a channel
//   i_fill_done / i_fill_id   : data fill for a channel has completed
//   o_id / o_size / o_id_vld  : granted channel, its clamped byte size, grant strobe
//   o_id_vld_p1               : grant strobe delayed one cycle (context write-back)
// master = context stage, slave = scheduler.
interface dcmac_0_axis_pkt_gen_ctx_sched_if;
    logic       i_dat_req;
    logic [2:0] i_dat_req_id;
    logic       i_fill_done;
    logic [2:0] i_fill_id;
    logic [2:0] o_id;
    logic       o_id_vld;
    logic       o_id_vld_p1;
    logic [7:0] o_size;

    modport master (
        output i_dat_req, i_dat_req_id, i_fill_done, i_fill_id,
        input  o_id, o_id_vld, o_id_vld_p1, o_size
    );

    modport slave (
        input  i_dat_req, i_dat_req_id, i_fill_done, i_fill_id,
        output o_id, o_id_vld, o_id_vld_p1, o_size
    );
endinterface

// File: rtl/dcmac_0_axis_pkt_gen_ctx_sched.sv
// Round-robin channel scheduler for the packet-generator buffer-context stage.
// Each cycle in RUN it grants the first eligible channel at or after the RR pointer,
// registering its id and clamped size. A channel is eligible when enabled, ready,
// has a non-zero size, fewer than MAX_PEND outstanding data requests and its reissue
// gap timer has expired.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_start / i_stop   : IDLE->RUN / RUN->DRAIN pulses (stop wins)
//   i_ch_en, i_ch_rdy  : per-channel enable and downstream ready
//   i_ch_size          : per-channel byte size, channel k at [8k+7:8k]
//   ctx_if             : request/fill inputs and grant outputs
//   o_busy             : state is not IDLE
//   o_err              : sticky pending-counter over/underflow or bad channel id
module dcmac_0_axis_pkt_gen_ctx_sched #(
    parameter int unsigned NUM_CH   = 6,
    parameter int unsigned MAX_PEND = 2,
    parameter int unsigned MAX_SIZE = 192,
    parameter int unsigned MIN_GAP  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [NUM_CH-1:0]      i_ch_en,
    input  logic [NUM_CH-1:0]      i_ch_rdy,
    input  logic [NUM_CH*8-1:0]    i_ch_size,
    dcmac_0_axis_pkt_gen_ctx_sched_if.slave ctx_if,
    output logic                   o_busy,
    output logic                   o_err
);
    localparam int unsigned PendW = $clog2(MAX_PEND + 1);
    localparam int unsigned GapW  = $clog2(MIN_GAP) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                         state_q, state_d;
    logic [2:0]                     ptr_q, ptr_d;
    logic [NUM_CH-1:0][PendW-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0][GapW-1:0]    gap_q, gap_d;
    logic [2:0]                     id_q, id_d;
    logic [7:0]                     size_q, size_d;
    logic                           vld_q, vld_d;
    logic                           vld_p1_q;
    logic                           err_q, err_d;

    logic [NUM_CH-1:0] elig;
    logic              found;
    logic [2:0]        pick;
    logic [7:0]        pick_size;
    logic [3:0]        idx;
    logic              grant;

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start && !i_stop) state_d = StRun;
            StRun:   if (i_stop) state_d = StDrain;
            StDrain: if (pend_q == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Eligibility and round-robin pick, searching upward from ptr_q with wrap
    always_comb begin
        elig      = '0;
        found     = 1'b0;
        pick      = '0;
        pick_size = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            elig[k] = i_ch_en[k] && i_ch_rdy[k] && (i_ch_size[8*k +: 8] != 8'd0) &&
                      (pend_q[k] < PendW'(MAX_PEND)) && (gap_q[k] == '0);
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 4'(ptr_q) + 4'(i);
            if (idx >= 4'(NUM_CH)) idx = idx - 4'(NUM_CH);
            if (!found && elig[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (pick == 3'(k)) pick_size = i_ch_size[8*k +: 8];
        end
    end

    assign grant = found && (state_q == StRun);

    // Grant registers, gap timers, pending counters
    always_comb begin
        ptr_d  = ptr_q;
        id_d   = id_q;
        size_d = size_q;
        vld_d  = 1'b0;
        pend_d = pend_q;
        gap_d  = gap_q;
        err_d  = err_q;

        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (gap_q[k] != '0) gap_d[k] = gap_q[k] - GapW'(1);
        end

        if (grant) begin
            vld_d  = 1'b1;
            id_d   = pick;
            size_d = (pick_size > 8'(MAX_SIZE)) ? 8'(MAX_SIZE) : pick_size;
            ptr_d  = (pick == 3'(NUM_CH - 1)) ? 3'd0 : pick + 3'd1;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (pick == 3'(k)) gap_d[k] = GapW'(MIN_GAP - 1);
            end
        end

        if (ctx_if.i_dat_req && (32'(ctx_if.i_dat_req_id) >= NUM_CH)) err_d = 1'b1;
        if (ctx_if.i_fill_done && (32'(ctx_if.i_fill_id) >= NUM_CH)) err_d = 1'b1;

        // Simultaneous inc and dec on one channel cancel out
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ctx_if.i_dat_req && (ctx_if.i_dat_req_id == 3'(k)) &&
                !(ctx_if.i_fill_done && (ctx_if.i_fill_id == 3'(k)))) begin
                if (pend_q[k] == PendW'(MAX_PEND)) err_d = 1'b1;
                else pend_d[k] = pend_q[k] + PendW'(1);
            end else if (ctx_if.i_fill_done && (ctx_if.i_fill_id == 3'(k)) &&
                         !(ctx_if.i_dat_req && (ctx_if.i_dat_req_id == 3'(k)))) begin
                if (pend_q[k] == '0) err_d = 1'b1;
                else pend_d[k] = pend_q[k] - PendW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            pend_q   <= '0;
            gap_q    <= '0;
            id_q     <= '0;
            size_q   <= '0;
            vld_q    <= 1'b0;
            vld_p1_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            pend_q   <= pend_d;
            gap_q    <= gap_d;
            id_q     <= id_d;
            size_q   <= size_d;
            vld_q    <= vld_d;
            vld_p1_q <= vld_q;
            err_q    <= err_d;
        end
    end

    assign ctx_if.o_id        = id_q;
    assign ctx_if.o_size      = size_q;
    assign ctx_if.o_id_vld    = vld_q;
    assign ctx_if.o_id_vld_p1 = vld_p1_q;
    assign o_busy             = (state_q != StIdle);
    assign o_err              = err_q;
endmodule

// File: tb/tb_dcmac_0_axis_pkt_gen_ctx_sched.sv
module tb_dcmac_0_axis_pkt_gen_ctx_sched;
    localparam int NUM_CH   = 6;
    localparam int MAX_PEND = 2;
    localparam int MAX_SIZE = 192;
    localparam int MIN_GAP  = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [5:0]  en = '0, rdy = '0;
    logic [47:0] size = '0;
    logic        busy, err;

    always #5 clk = ~clk;

    dcmac_0_axis_pkt_gen_ctx_sched_if ctx_if ();

    dcmac_0_axis_pkt_gen_ctx_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (start),
        .i_stop    (stop),
        .i_ch_en   (en),
        .i_ch_rdy  (rdy),
        .i_ch_size (size),
        .ctx_if    (ctx_if.slave),
        .o_busy    (busy),
        .o_err     (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state after the most recent clock edge
    int  m_state, m_ptr, m_id, m_size, cyc;
    bit  m_vld, m_vld_p1, m_err;
    int  m_pend[NUM_CH];
    int  m_last[NUM_CH];

    task automatic model_reset();
        m_state = M_IDLE; m_ptr = 0; m_id = 0; m_size = 0;
        m_vld = 0; m_vld_p1 = 0; m_err = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_pend[k] = 0;
            m_last[k] = -1000;
        end
    endtask

    function automatic int ch_size(input int k);
        return int'(size[8*k +: 8]);
    endfunction

    task automatic model_step();
        int g;
        bool_all0: begin end
        g = -1;
        if (m_state == M_RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int k;
                k = (m_ptr + i) % NUM_CH;
                if (g < 0 && en[k] && rdy[k] && ch_size(k) != 0 && m_pend[k] < MAX_PEND &&
                    cyc - m_last[k] >= MIN_GAP)
                    g = k;
            end
        end
        m_vld_p1 = m_vld;
        if (g >= 0) begin
            m_vld = 1;
            m_id = g;
            m_size = (ch_size(g) > MAX_SIZE) ? MAX_SIZE : ch_size(g);
            m_ptr = (g + 1) % NUM_CH;
            m_last[g] = cyc;
        end else begin
            m_vld = 0;
        end
        begin
            int sum;
            sum = 0;
            for (int k = 0; k < NUM_CH; k++) sum += m_pend[k];
            case (m_state)
                M_IDLE:  if (start && !stop) m_state = M_RUN;
                M_RUN:   if (stop) m_state = M_DRAIN;
                default: if (sum == 0) m_state = M_IDLE;
            endcase
        end
        if (ctx_if.i_dat_req && ctx_if.i_dat_req_id >= NUM_CH) m_err = 1;
        if (ctx_if.i_fill_done && ctx_if.i_fill_id >= NUM_CH) m_err = 1;
        for (int k = 0; k < NUM_CH; k++) begin
            int delta;
            delta = 0;
            if (ctx_if.i_dat_req && ctx_if.i_dat_req_id == k) delta++;
            if (ctx_if.i_fill_done && ctx_if.i_fill_id == k) delta--;
            if (m_pend[k] + delta > MAX_PEND || m_pend[k] + delta < 0) m_err = 1;
            else m_pend[k] += delta;
        end
        cyc++;
    endtask

    task automatic compare_all();
        check_eq("vld", 32'(ctx_if.o_id_vld), 32'(m_vld));
        check_eq("id", 32'(ctx_if.o_id), m_id);
        check_eq("size", 32'(ctx_if.o_size), m_size);
        check_eq("vld_p1", 32'(ctx_if.o_id_vld_p1), 32'(m_vld_p1));
        check_eq("busy", 32'(busy), 32'(m_state != M_IDLE));
        check_eq("err", 32'(err), 32'(m_err));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_req(input bit r, input int rid, input bit f, input int fid);
        ctx_if.i_dat_req    = r;
        ctx_if.i_dat_req_id = 3'(rid);
        ctx_if.i_fill_done  = f;
        ctx_if.i_fill_id    = 3'(fid);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_vld"}, 32'(ctx_if.o_id_vld), 0);
        check_eq({tag, "_id"}, 32'(ctx_if.o_id), 0);
        check_eq({tag, "_size"}, 32'(ctx_if.o_size), 0);
        check_eq({tag, "_p1"}, 32'(ctx_if.o_id_vld_p1), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        set_req(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // 1: all channels, size 64 -> 0,1,2,3,4,5,0...
        en = 6'h3f; rdy = 6'h3f; size = {6{8'd64}};
        start = 1; step(); start = 0;
        repeat (14) step();

        // 2: only ch3, size 200 -> every 2nd cycle, clamped
        en = 6'b001000; size[31:24] = 8'd200;
        repeat (8) step();
        check_eq("t2_clamp", 32'(ctx_if.o_size), 192);

        // 3: ch1 blocked by two requests, released by one fill
        en = 6'b000110; size = {6{8'd64}};
        set_req(1, 1, 0, 0); step(); step();
        set_req(0, 0, 0, 0); repeat (6) step();
        set_req(0, 0, 1, 1); step();
        set_req(0, 0, 0, 0); repeat (4) step();
        set_req(0, 0, 1, 1); step();
        set_req(0, 0, 0, 0);

        // 4: stop with pend[4]=2, drain via fills
        en = 6'b010000;
        set_req(1, 4, 0, 0); step(); step();
        set_req(0, 0, 0, 0); step();
        stop = 1; step(); stop = 0;
        check_eq("t4_vld", 32'(ctx_if.o_id_vld), 0);
        check_eq("t4_busy", 32'(busy), 1);
        start = 1; step(); start = 0;
        repeat (2) step();
        set_req(0, 0, 1, 4); step(); step();
        set_req(0, 0, 0, 0); step();
        check_eq("t4_idle", 32'(busy), 0);

        // 5: same-cycle inc/dec, then underflow on ch0
        set_req(1, 5, 0, 0); step();
        set_req(1, 5, 1, 5); step();
        set_req(0, 0, 1, 5); step();
        check_eq("t5_noerr", 32'(err), 0);
        set_req(0, 0, 1, 0); step();
        set_req(0, 0, 0, 0); step(); step();
        check_eq("t5_err", 32'(err), 1);

        // 6: asynchronous reset mid-run with pending requests
        en = 6'h3f; start = 1; step(); start = 0;
        set_req(1, 2, 0, 0); step();
        set_req(0, 0, 0, 0); step();
        #3 rst_n = 1'b0;
        #1 check_zero_outputs("areset");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step();
        check_eq("t6_idle", 32'(busy), 0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) begin
                @(negedge clk) rst_n = 1'b0;
                model_reset();
                @(negedge clk) rst_n = 1'b1;
            end
            start = ($urandom % 20) == 0;
            stop  = !start && (($urandom % 40) == 0);
            en    = 6'($urandom);
            rdy   = 6'($urandom | $urandom);
            for (int k = 0; k < NUM_CH; k++) begin
                if (($urandom % 10) == 0) size[8*k +: 8] = 8'($urandom);
                if (($urandom % 40) == 0) size[8*k +: 8] = 8'd0;
            end
            set_req(($urandom % 3) == 0,
                    (($urandom % 32) == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6),
                    ($urandom % 3) == 0,
                    (($urandom % 32) == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
